// File: rtl/scan_pkg.sv
// scan_pkg: state encoding, window counter width and minimum-width clamps shared
// by the scanner transmit timing and echo-timing blocks.
package scan_pkg;
    typedef enum logic [1:0] {IDLE, FIRE, LISTEN, HOLD} state_t;
    localparam int CNT_W = 12;
    localparam logic [7:0] PW_MIN = 8'd1;
    localparam logic [7:0] H_MIN = 8'd1;
    function automatic logic [7:0] clamp_min(input logic [7:0] v, input logic [7:0] lo);
        return (v < lo) ? lo : v;
    endfunction
endpackage

// File: rtl/laser_fire_ctrl.sv
// laser_fire_ctrl: per-shot laser trigger and receive-window timing with holdoff,
// per-revolution shot index and sticky overrun flag for lost requests.
module laser_fire_ctrl
    import scan_pkg::*;
#(
    parameter int IDX_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             shot_req,
    input  logic             frame_sync,
    input  logic             clr_err,
    input  logic [7:0]       pulse_w,
    input  logic [11:0]      win_len,
    input  logic [7:0]       holdoff,
    output logic             laser_trig,
    output logic             data_en,
    output logic             busy,
    output logic             shot_done,
    output logic [IDX_W-1:0] shot_idx,
    output logic             overrun
);
    state_t state;
    logic [CNT_W-1:0] cnt, pw_lat, w_lat, h_lat, pw_c, w_c, h_c;
    logic req_bad;

    always_comb begin
        pw_c = {{(CNT_W-8){1'b0}}, clamp_min(pulse_w, PW_MIN)};
        h_c = {{(CNT_W-8){1'b0}}, clamp_min(holdoff, H_MIN)};
        w_c = (win_len > pw_c) ? win_len : pw_c;
        req_bad = shot_req && (state != IDLE || !enable);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt <= '0;
            pw_lat <= '0;
            w_lat <= '0;
            h_lat <= '0;
            laser_trig <= 1'b0;
            data_en <= 1'b0;
            busy <= 1'b0;
            shot_done <= 1'b0;
            shot_idx <= '0;
            overrun <= 1'b0;
        end else begin
            shot_done <= 1'b0;
            shot_idx <= frame_sync ? '0 : shot_done ? shot_idx + IDX_W'(1) : shot_idx;
            overrun <= req_bad ? 1'b1 : clr_err ? 1'b0 : overrun;
            case (state)
                IDLE:
                    if (shot_req && enable) begin
                        state <= FIRE;
                        laser_trig <= 1'b1;
                        data_en <= 1'b1;
                        busy <= 1'b1;
                        pw_lat <= pw_c;
                        w_lat <= w_c;
                        h_lat <= h_c;
                        cnt <= pw_c - CNT_W'(1);
                    end
                FIRE, LISTEN:
                    // abort and natural window end share the HOLD entry; only the latter reports done
                    if (!enable || (cnt == '0 && (state == LISTEN || w_lat == pw_lat))) begin
                        state <= HOLD;
                        laser_trig <= 1'b0;
                        data_en <= 1'b0;
                        shot_done <= enable;
                        cnt <= h_lat - CNT_W'(1);
                    end else if (cnt == '0) begin
                        state <= LISTEN;
                        laser_trig <= 1'b0;
                        cnt <= w_lat - pw_lat - CNT_W'(1);
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                HOLD:
                    if (cnt == '0) begin
                        state <= IDLE;
                        busy <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_laser_fire_ctrl.sv
// tb_laser_fire_ctrl: directed shots with a per-cycle waveform scoreboard plus
// direct checks of shot index, overrun and reset behaviour.
module tb_laser_fire_ctrl;
    localparam int IDX_W = 2;
    logic clk = 1'b0, rst = 1'b0, enable = 1'b0, shot_req = 1'b0, frame_sync = 1'b0, clr_err = 1'b0;
    logic [7:0] pulse_w = '0, holdoff = '0;
    logic [11:0] win_len = '0;
    logic laser_trig, data_en, busy, shot_done, overrun;
    logic [IDX_W-1:0] shot_idx;
    typedef struct {
        logic [3:0] v;
        string tag;
    } exp_t;
    exp_t exp_q[$];
    int checks = 0, errors = 0;

    laser_fire_ctrl #(.IDX_W(IDX_W)) dut (
        .clk(clk), .rst(rst), .enable(enable), .shot_req(shot_req), .frame_sync(frame_sync),
        .clr_err(clr_err), .pulse_w(pulse_w), .win_len(win_len), .holdoff(holdoff),
        .laser_trig(laser_trig), .data_en(data_en), .busy(busy), .shot_done(shot_done),
        .shot_idx(shot_idx), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // expected {laser_trig,data_en,busy,shot_done} per cycle, from the first cycle after acceptance
    task automatic push_shot(input int pw, input int w, input int h, input string tag);
        int p, ww, hh;
        p = (pw == 0) ? 1 : pw;
        ww = (w > p) ? w : p;
        hh = (h == 0) ? 1 : h;
        for (int i = 0; i < p; i++) exp_q.push_back('{4'b1110, tag});
        for (int i = p; i < ww; i++) exp_q.push_back('{4'b0110, tag});
        for (int i = 0; i < hh; i++) exp_q.push_back('{(i == 0) ? 4'b0011 : 4'b0010, tag});
        exp_q.push_back('{4'b0000, tag});
    endtask

    task automatic fire_shot(input string tag);
        shot_req = 1'b1;
        tick(1);
        shot_req = 1'b0;
        push_shot(int'(pulse_w), int'(win_len), int'(holdoff), tag);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) tick(1);
        chk({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic set_cfg(input logic [7:0] pw, input logic [11:0] w, input logic [7:0] h);
        pulse_w = pw;
        win_len = w;
        holdoff = h;
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                if (exp_q.size() != 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk(e.tag, 32'({laser_trig, data_en, busy, shot_done}), 32'(e.v));
                end
            end
        join_none

        tick(2);
        chk("reset_outs", 32'({laser_trig, data_en, busy, shot_done, overrun, shot_idx}), 32'd0);
        rst = 1'b1;
        enable = 1'b1;
        set_cfg(8'd4, 12'd20, 8'd3);
        tick(2);

        fire_shot("t1");
        drain("t1");
        chk("t1_idx", 32'(shot_idx), 32'd1);
        chk("t1_ovr", 32'(overrun), 32'd0);

        fire_shot("t2");
        tick(9);
        shot_req = 1'b1;
        tick(1);
        shot_req = 1'b0;
        chk("t2_busy_ovr", 32'(overrun), 32'd1);
        set_cfg(8'd1, 12'd5, 8'd9);
        tick(1);
        set_cfg(8'd4, 12'd20, 8'd3);
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        chk("t2_clr", 32'(overrun), 32'd0);
        shot_req = 1'b1;
        clr_err = 1'b1;
        tick(1);
        shot_req = 1'b0;
        clr_err = 1'b0;
        chk("t2_set_wins", 32'(overrun), 32'd1);
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        chk("t2_clr2", 32'(overrun), 32'd0);
        tick(8);
        shot_req = 1'b1;
        tick(1);
        chk("t2_hold_exit_ovr", 32'(overrun), 32'd1);
        tick(1);
        shot_req = 1'b0;
        push_shot(4, 20, 3, "t2b");
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        chk("t2b_clr", 32'(overrun), 32'd0);
        drain("t2b");
        chk("t2_idx", 32'(shot_idx), 32'd3);

        set_cfg(8'd0, 12'd0, 8'd0);
        fire_shot("t3");
        drain("t3");
        chk("t3_idx_wrap", 32'(shot_idx), 32'd0);

        set_cfg(8'd4, 12'd20, 8'd3);
        shot_req = 1'b1;
        tick(1);
        shot_req = 1'b0;
        repeat (3) exp_q.push_back('{4'b1110, "t4"});
        repeat (3) exp_q.push_back('{4'b0010, "t4"});
        exp_q.push_back('{4'b0000, "t4"});
        tick(2);
        enable = 1'b0;
        drain("t4");
        chk("t4_idx", 32'(shot_idx), 32'd0);
        shot_req = 1'b1;
        tick(1);
        shot_req = 1'b0;
        chk("t4_dis_ovr", 32'(overrun), 32'd1);
        chk("t4_dis_busy", 32'(busy), 32'd0);
        clr_err = 1'b1;
        enable = 1'b1;
        tick(1);
        clr_err = 1'b0;
        chk("t4_clr", 32'(overrun), 32'd0);

        set_cfg(8'd1, 12'd2, 8'd1);
        for (int k = 0; k < 5; k++) begin
            fire_shot("t5");
            drain("t5");
            chk("t5_idx", 32'(shot_idx), 32'((k + 1) % 4));
        end
        fire_shot("t5fs");
        tick(2);
        frame_sync = 1'b1;
        tick(1);
        frame_sync = 1'b0;
        drain("t5fs");
        chk("t5_fs_wins", 32'(shot_idx), 32'd0);

        set_cfg(8'd4, 12'd20, 8'd3);
        fire_shot("t6a");
        tick(7);
        exp_q.delete();
        rst = 1'b0;
        #1;
        chk("t6_async_rst", 32'({laser_trig, data_en, busy, shot_done, overrun, shot_idx}), 32'd0);
        tick(2);
        rst = 1'b1;
        tick(1);
        fire_shot("t6");
        drain("t6");
        chk("t6_idx", 32'(shot_idx), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
